// File: rtl/rtsnoc_local_port_buffer.sv
// Buffer between the RTSNoC Wishbone slave NoC-side port and the router local port.
// TX/RX FIFOs with paced single-cycle router strobes, fill levels and a sticky overflow flag.
module rtsnoc_local_port_buffer #(
   parameter int SOC_SIZE_X     = 1,
   parameter int SOC_SIZE_Y     = 1,
   parameter int NOC_DATA_WIDTH = 32,
   parameter int TX_DEPTH_LOG2  = 2,
   parameter int RX_DEPTH_LOG2  = 2,
   localparam int BUS = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [BUS-1:0]           s_din_i,
   input  logic                     s_wr_i,
   output logic                     s_wait_o,
   output logic [BUS-1:0]           s_dout_o,
   output logic                     s_nd_o,
   input  logic                     s_rd_i,
   output logic [BUS-1:0]           r_din_o,
   output logic                     r_wr_o,
   input  logic                     r_wait_i,
   input  logic [BUS-1:0]           r_dout_i,
   input  logic                     r_nd_i,
   output logic                     r_rd_o,
   output logic [TX_DEPTH_LOG2:0]   tx_level_o,
   output logic [RX_DEPTH_LOG2:0]   rx_level_o,
   output logic                     tx_ovf_o,
   input  logic                     ovf_clr_i
);

   localparam int TX_DEPTH = 2**TX_DEPTH_LOG2;
   localparam int RX_DEPTH = 2**RX_DEPTH_LOG2;
   localparam logic [TX_DEPTH_LOG2:0] TX_FULL_LVL = (TX_DEPTH_LOG2+1)'(TX_DEPTH);
   localparam logic [RX_DEPTH_LOG2:0] RX_FULL_LVL = (RX_DEPTH_LOG2+1)'(RX_DEPTH);
   localparam logic [TX_DEPTH_LOG2:0] TX_ONE      = (TX_DEPTH_LOG2+1)'(1);
   localparam logic [RX_DEPTH_LOG2:0] RX_ONE      = (RX_DEPTH_LOG2+1)'(1);

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_SEND = 2'd1;
   localparam logic [1:0] T_HOLD = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ACK  = 2'd1;
   localparam logic [1:0] R_GAP  = 2'd2;

   logic [BUS-1:0]           tx_mem_r [TX_DEPTH];
   logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_r;
   logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr_r;
   logic [TX_DEPTH_LOG2:0]   tx_level_r;
   logic                     tx_ovf_r;
   logic [1:0]               tx_state_r;
   logic [BUS-1:0]           r_din_r;
   logic                     r_wr_r;
   logic                     tx_full_s;
   logic                     tx_empty_s;
   logic                     tx_push_s;
   logic                     tx_pop_s;

   logic [BUS-1:0]           rx_mem_r [RX_DEPTH];
   logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_r;
   logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr_r;
   logic [RX_DEPTH_LOG2:0]   rx_level_r;
   logic [1:0]               rx_state_r;
   logic                     r_rd_r;
   logic                     rx_full_s;
   logic                     rx_empty_s;
   logic                     rx_push_s;
   logic                     rx_pop_s;
   logic [BUS-1:0]           s_dout_s;

   // TX FIFO status and handshake decode; r_wait_i only matters while idle
   always_comb begin
      tx_full_s  = (tx_level_r == TX_FULL_LVL);
      tx_empty_s = (tx_level_r == {(TX_DEPTH_LOG2+1){1'b0}});
      tx_push_s  = s_wr_i && !tx_full_s;
      tx_pop_s   = (tx_state_r == T_IDLE) && !tx_empty_s && !r_wait_i;
   end

   // TX storage
   always_ff @(posedge clk_i) begin
      if (tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r] <= s_din_i;
      end
   end

   // TX pointers, level and sticky overflow (a new overflow beats a clear)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_wr_ptr_r <= {TX_DEPTH_LOG2{1'b0}};
         tx_rd_ptr_r <= {TX_DEPTH_LOG2{1'b0}};
         tx_level_r  <= {(TX_DEPTH_LOG2+1){1'b0}};
         tx_ovf_r    <= 1'b0;
      end else begin
         if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + {{(TX_DEPTH_LOG2-1){1'b0}}, 1'b1};
         if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + {{(TX_DEPTH_LOG2-1){1'b0}}, 1'b1};
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_level_r <= tx_level_r + TX_ONE;
            2'b01:   tx_level_r <= tx_level_r - TX_ONE;
            default: tx_level_r <= tx_level_r;
         endcase
         if (s_wr_i && tx_full_s) begin
            tx_ovf_r <= 1'b1;
         end else if (ovf_clr_i) begin
            tx_ovf_r <= 1'b0;
         end
      end
   end

   // TX pacing FSM: load, one-cycle write strobe, guard cycle
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_state_r <= T_IDLE;
         r_din_r    <= {BUS{1'b0}};
         r_wr_r     <= 1'b0;
      end else begin
         case (tx_state_r)
            T_IDLE: begin
               if (tx_pop_s) begin
                  r_din_r    <= tx_mem_r[tx_rd_ptr_r];
                  r_wr_r     <= 1'b1;
                  tx_state_r <= T_SEND;
               end
            end
            T_SEND: begin
               r_wr_r     <= 1'b0;
               tx_state_r <= T_HOLD;
            end
            T_HOLD: begin
               tx_state_r <= T_IDLE;
            end
            default: begin
               r_wr_r     <= 1'b0;
               tx_state_r <= T_IDLE;
            end
         endcase
      end
   end

   // RX FIFO status, handshake decode and zero-masked head
   always_comb begin
      rx_full_s  = (rx_level_r == RX_FULL_LVL);
      rx_empty_s = (rx_level_r == {(RX_DEPTH_LOG2+1){1'b0}});
      rx_push_s  = (rx_state_r == R_IDLE) && r_nd_i && !rx_full_s;
      rx_pop_s   = s_rd_i && !rx_empty_s;
      if (!rx_empty_s) begin
         s_dout_s = rx_mem_r[rx_rd_ptr_r];
      end else begin
         s_dout_s = {BUS{1'b0}};
      end
   end

   // RX storage
   always_ff @(posedge clk_i) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r] <= r_dout_i;
      end
   end

   // RX pointers and level
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_wr_ptr_r <= {RX_DEPTH_LOG2{1'b0}};
         rx_rd_ptr_r <= {RX_DEPTH_LOG2{1'b0}};
         rx_level_r  <= {(RX_DEPTH_LOG2+1){1'b0}};
      end else begin
         if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + {{(RX_DEPTH_LOG2-1){1'b0}}, 1'b1};
         if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + {{(RX_DEPTH_LOG2-1){1'b0}}, 1'b1};
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_level_r <= rx_level_r + RX_ONE;
            2'b01:   rx_level_r <= rx_level_r - RX_ONE;
            default: rx_level_r <= rx_level_r;
         endcase
      end
   end

   // RX pacing FSM: capture, one-cycle read strobe, guard cycle for r_nd_i to settle
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_state_r <= R_IDLE;
         r_rd_r     <= 1'b0;
      end else begin
         case (rx_state_r)
            R_IDLE: begin
               if (rx_push_s) begin
                  r_rd_r     <= 1'b1;
                  rx_state_r <= R_ACK;
               end
            end
            R_ACK: begin
               r_rd_r     <= 1'b0;
               rx_state_r <= R_GAP;
            end
            R_GAP: begin
               rx_state_r <= R_IDLE;
            end
            default: begin
               r_rd_r     <= 1'b0;
               rx_state_r <= R_IDLE;
            end
         endcase
      end
   end

   assign s_wait_o   = tx_full_s;
   assign s_nd_o     = !rx_empty_s;
   assign s_dout_o   = s_dout_s;
   assign r_din_o    = r_din_r;
   assign r_wr_o     = r_wr_r;
   assign r_rd_o     = r_rd_r;
   assign tx_level_o = tx_level_r;
   assign rx_level_o = rx_level_r;
   assign tx_ovf_o   = tx_ovf_r;

endmodule

// File: tb/tb_rtsnoc_local_port_buffer.sv
// Self-checking bench for rtsnoc_local_port_buffer: vector table for TX fill/overflow,
// scoreboard queues for flit order in both directions, hand sequences for timing corners.
module tb_rtsnoc_local_port_buffer;

   localparam int BUS = 42;

   logic           clk = 1'b0;
   logic           rst_n_i;
   logic [BUS-1:0] s_din_i;
   logic           s_wr_i;
   logic           s_wait_o;
   logic [BUS-1:0] s_dout_o;
   logic           s_nd_o;
   logic           s_rd_i;
   logic [BUS-1:0] r_din_o;
   logic           r_wr_o;
   logic           r_wait_i;
   logic [BUS-1:0] r_dout_i = '0;
   logic           r_nd_i = 1'b0;
   logic           r_rd_o;
   logic [2:0]     tx_level_o;
   logic [2:0]     rx_level_o;
   logic           tx_ovf_o;
   logic           ovf_clr_i;

   always #5 clk = ~clk;

   rtsnoc_local_port_buffer dut (
      .clk_i(clk), .rst_n_i(rst_n_i),
      .s_din_i(s_din_i), .s_wr_i(s_wr_i), .s_wait_o(s_wait_o),
      .s_dout_o(s_dout_o), .s_nd_o(s_nd_o), .s_rd_i(s_rd_i),
      .r_din_o(r_din_o), .r_wr_o(r_wr_o), .r_wait_i(r_wait_i),
      .r_dout_i(r_dout_i), .r_nd_i(r_nd_i), .r_rd_o(r_rd_o),
      .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
      .tx_ovf_o(tx_ovf_o), .ovf_clr_i(ovf_clr_i)
   );

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   logic [BUS-1:0] tx_exp[$];
   logic [BUS-1:0] rx_exp[$];
   logic [BUS-1:0] rtr_q[$];
   logic rtr_en = 1'b0;

   typedef struct {
      logic           wr;
      logic [BUS-1:0] din;
      logic           clr;
      logic           acc;
      logic [2:0]     lvl;
      logic           full;
      logic           ovf;
   } vec_t;
   vec_t vecs[9];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endfunction

   function automatic void miss(input string nm, input logic [63:0] act);
      checks++;
      fails++;
      $display("FAIL %s: got %0h with nothing expected", nm, act);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // TX scoreboard: every router write strobe must carry the next expected flit
   always @(negedge clk) begin
      if (rst_n_i && r_wr_o) begin
         wr_pulses++;
         if (tx_exp.size() == 0) miss("tx_unexpected_flit", r_din_o);
         else chk("tx_flit_data", r_din_o, tx_exp.pop_front());
      end
   end

   // Router model: offers rtr_q head, retires it on r_rd_o, hands it to the RX scoreboard
   always @(negedge clk) begin
      if (rst_n_i && r_rd_o) begin
         rd_pulses++;
         if (rtr_q.size() == 0) miss("rx_unexpected_rd", 64'(r_rd_o));
         else rx_exp.push_back(rtr_q.pop_front());
      end
      r_nd_i   = rtr_en && (rtr_q.size() > 0);
      r_dout_i = (rtr_q.size() > 0) ? rtr_q[0] : '0;
   end

   task automatic slave_pop(input string nm);
      @(negedge clk); #1;
      if (rx_exp.size() == 0) miss(nm, s_dout_o);
      else chk(nm, s_dout_o, rx_exp.pop_front());
      s_rd_i = 1'b1;
      @(negedge clk); #1;
      s_rd_i = 1'b0;
   endtask

   task automatic wait_rd(input string nm, input int max);
      int start;
      start = rd_pulses;
      for (int i = 0; i < max && rd_pulses == start; i++) begin
         @(negedge clk); #1;
      end
      chk(nm, 64'(rd_pulses > start), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc[4];
      int np;
      int start;
      int ntx;
      bit lvl_ok;
      bit seen;

      vecs[0] = '{1'b1, 42'd1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 42'd2, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 42'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 42'd4, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 42'd5, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 42'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 42'd6, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 42'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 42'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};

      rst_n_i = 1'b0; s_din_i = '0; s_wr_i = 1'b0; s_rd_i = 1'b0;
      r_wait_i = 1'b0; ovf_clr_i = 1'b0;
      #2;
      chk("rst_s_wait", 64'(s_wait_o), 64'd0);
      chk("rst_s_nd", 64'(s_nd_o), 64'd0);
      chk("rst_s_dout", 64'(s_dout_o), 64'd0);
      chk("rst_r_din", 64'(r_din_o), 64'd0);
      chk("rst_r_wr", 64'(r_wr_o), 64'd0);
      chk("rst_r_rd", 64'(r_rd_o), 64'd0);
      chk("rst_levels", {58'd0, tx_level_o, rx_level_o}, 64'd0);
      chk("rst_ovf", 64'(tx_ovf_o), 64'd0);
      repeat (3) @(negedge clk);
      #1 rst_n_i = 1'b1;

      // Single TX flit: strobe two cycles after the push
      @(negedge clk); #1;
      s_wr_i = 1'b1; s_din_i = 42'h0AB_CDEF_0123; tx_exp.push_back(42'h0AB_CDEF_0123);
      @(negedge clk);
      chk("tx1_level_after_push", 64'(tx_level_o), 64'd1);
      chk("tx1_no_early_wr", 64'(r_wr_o), 64'd0);
      #1 s_wr_i = 1'b0;
      @(negedge clk);
      chk("tx1_wr_pulse", 64'(r_wr_o), 64'd1);
      chk("tx1_r_din", 64'(r_din_o), 64'h0AB_CDEF_0123);
      chk("tx1_level_zero", 64'(tx_level_o), 64'd0);
      @(negedge clk);
      chk("tx1_wr_single", 64'(r_wr_o), 64'd0);
      chk("tx1_r_din_held", 64'(r_din_o), 64'h0AB_CDEF_0123);

      // Back-pressure, fill and overflow driven from the vector table
      @(negedge clk); #1 r_wait_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); #1;
         s_wr_i = vecs[i].wr; s_din_i = vecs[i].din; ovf_clr_i = vecs[i].clr;
         if (vecs[i].acc) tx_exp.push_back(vecs[i].din);
         @(negedge clk);
         chk($sformatf("vec%0d_level", i), 64'(tx_level_o), 64'(vecs[i].lvl));
         chk($sformatf("vec%0d_s_wait", i), 64'(s_wait_o), 64'(vecs[i].full));
         chk($sformatf("vec%0d_ovf", i), 64'(tx_ovf_o), 64'(vecs[i].ovf));
         chk($sformatf("vec%0d_no_wr", i), 64'(r_wr_o), 64'd0);
         #1 s_wr_i = 1'b0; ovf_clr_i = 1'b0;
      end
      @(negedge clk); #1 r_wait_i = 1'b0;
      np = 0;
      start = wr_pulses;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (r_wr_o && np < 4) begin
            pc[np] = cyc;
            np++;
         end
      end
      chk("bp_pulse_count", 64'(wr_pulses - start), 64'd4);
      for (int k = 1; k < 4; k++) chk($sformatf("bp_gap%0d", k), 64'(pc[k] - pc[k-1]), 64'd3);
      chk("bp_level_drained", 64'(tx_level_o), 64'd0);
      chk("bp_scoreboard_empty", 64'(tx_exp.size()), 64'd0);

      // Single RX flit
      @(negedge clk); #1; rtr_q.push_back(42'h155); rtr_en = 1'b1;
      wait_rd("rx1_rd_pulse", 10);
      @(negedge clk); #1;
      chk("rx1_s_nd", 64'(s_nd_o), 64'd1);
      chk("rx1_s_dout", 64'(s_dout_o), 64'h155);
      chk("rx1_rd_single", 64'(r_rd_o), 64'd0);
      slave_pop("rx1_pop_data");
      chk("rx1_s_nd_cleared", 64'(s_nd_o), 64'd0);
      chk("rx1_s_dout_zero", 64'(s_dout_o), 64'd0);
      chk("rx1_level_zero", 64'(rx_level_o), 64'd0);

      // RX full: router keeps offering, slave idle
      start = rd_pulses;
      for (int k = 0; k < 6; k++) rtr_q.push_back(42'h200 + 42'(k));
      repeat (40) @(negedge clk);
      #1;
      chk("rxfull_rd_count", 64'(rd_pulses - start), 64'd4);
      chk("rxfull_level", 64'(rx_level_o), 64'd4);
      chk("rxfull_rd_low", 64'(r_rd_o), 64'd0);
      chk("rxfull_s_nd", 64'(s_nd_o), 64'd1);
      slave_pop("rxfull_head");
      wait_rd("rxfull_fifth_accepted", 3);
      for (int k = 0; k < 5; k++) begin
         for (int w = 0; w < 10 && !s_nd_o; w++) begin
            @(negedge clk); #1;
         end
         slave_pop("rxfull_drain");
      end
      repeat (6) @(negedge clk);
      #1;
      chk("rxfull_level_end", 64'(rx_level_o), 64'd0);
      chk("rxfull_router_empty", 64'(rtr_q.size()), 64'd0);
      chk("rxfull_sb_empty", 64'(rx_exp.size()), 64'd0);

      // Both directions concurrently
      for (int k = 0; k < 8; k++) rtr_q.push_back(42'h300 + 42'(k));
      ntx = 0;
      lvl_ok = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk); #1;
         if (tx_level_o > 3'd4 || rx_level_o > 3'd4) lvl_ok = 1'b0;
         if (i % 3 == 0 && ntx < 6) begin
            s_wr_i = 1'b1; s_din_i = 42'h400 + 42'(ntx);
            tx_exp.push_back(42'h400 + 42'(ntx));
            ntx++;
         end else begin
            s_wr_i = 1'b0;
         end
         if (s_nd_o) begin
            if (rx_exp.size() == 0) miss("sim_rx_unexpected", s_dout_o);
            else chk("sim_rx_data", s_dout_o, rx_exp.pop_front());
            s_rd_i = 1'b1;
         end else begin
            s_rd_i = 1'b0;
         end
      end
      s_wr_i = 1'b0; s_rd_i = 1'b0;
      chk("sim_levels_bounded", 64'(lvl_ok), 64'd1);
      chk("sim_tx_all_sent", 64'(tx_exp.size()), 64'd0);
      chk("sim_rx_all_read", 64'(rx_exp.size() + rtr_q.size()), 64'd0);

      // Reset during a TX strobe with RX traffic in flight
      @(negedge clk); #1;
      rtr_q.push_back(42'h500); rtr_q.push_back(42'h501);
      s_wr_i = 1'b1; s_din_i = 42'h600; tx_exp.push_back(42'h600);
      @(negedge clk); #1;
      s_din_i = 42'h601; tx_exp.push_back(42'h601);
      @(negedge clk); #1;
      s_wr_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (r_wr_o) seen = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      chk("mid_rst_reached_send", 64'(seen), 64'd1);
      rst_n_i = 1'b0; rtr_en = 1'b0;
      rtr_q.delete(); tx_exp.delete(); rx_exp.delete();
      #1;
      chk("mid_rst_r_wr_drop", 64'(r_wr_o), 64'd0);
      chk("mid_rst_r_rd_drop", 64'(r_rd_o), 64'd0);
      chk("mid_rst_levels", {58'd0, tx_level_o, rx_level_o}, 64'd0);
      chk("mid_rst_s_nd", 64'(s_nd_o), 64'd0);
      repeat (2) @(negedge clk);
      #1 rst_n_i = 1'b1;
      start = wr_pulses;
      repeat (12) @(negedge clk);
      #1;
      chk("post_rst_no_stale_tx", 64'(wr_pulses - start), 64'd0);
      chk("post_rst_no_stale_rx", 64'(s_nd_o), 64'd0);
      chk("post_rst_levels", {58'd0, tx_level_o, rx_level_o}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/rtsnoc_local_port_buffer.md
Name: rtsnoc_local_port_buffer

Overview:
- Buffering stage between the RTSNoC Wishbone slave's NoC-side port and the router local port.
- Decouples CPU-side bursts from router back-pressure using a TX FIFO (slave→router) and an RX FIFO (router→slave).
- Converts the slave's free-running push/pop strobes into paced single-cycle router wr/rd pulses.
- Exposes fill levels and a sticky overflow flag for debug and interrupt logic.

Parameters:
SOC_SIZE_X, 1, log2 of mesh X size
SOC_SIZE_Y, 1, log2 of mesh Y size
NOC_DATA_WIDTH, 32, flit payload width
TX_DEPTH_LOG2, 2, TX FIFO depth = 2**TX_DEPTH_LOG2 (default 4)
RX_DEPTH_LOG2, 2, RX FIFO depth = 2**RX_DEPTH_LOG2 (default 4)
BUS (localparam), NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6, flit width (default 42)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  asynchronous, active-low reset
s_din_i  in  BUS  flit from slave
s_wr_i  in  1  push s_din_i into TX FIFO
s_wait_o  out  1  TX FIFO full
s_dout_o  out  BUS  RX FIFO head (first-word fall-through)
s_nd_o  out  1  RX FIFO not empty
s_rd_i  in  1  pop RX FIFO head
r_din_o  out  BUS  flit to router
r_wr_o  out  1  router write strobe
r_wait_i  in  1  router busy
r_dout_i  in  BUS  flit from router
r_nd_i  in  1  router has flit on r_dout_i
r_rd_o  out  1  router read strobe
tx_level_o  out  TX_DEPTH_LOG2+1  TX occupancy
rx_level_o  out  RX_DEPTH_LOG2+1  RX occupancy
tx_ovf_o  out  1  sticky: push attempted while full
ovf_clr_i  in  1  clears tx_ovf_o

Behaviour:
Reset:
- rst_n_i low clears outputs asynchronously: s_wait_o=0, s_nd_o=0, s_dout_o=0, r_din_o=0, r_wr_o=0, r_rd_o=0, levels=0, tx_ovf_o=0.
- Both FSMs return to IDLE; pointers are cleared; in-flight flits are discarded.

TX FIFO:
- Push when s_wr_i && !full.
- s_wr_i while full: flit dropped, tx_ovf_o=1 next cycle.
- ovf_clr_i clears tx_ovf_o; if ovf_clr_i and a new overflow occur in the same cycle, set wins.
- s_wait_o = (tx_level==depth).
- Simultaneous push and pop: level unchanged. Pointers wrap modulo depth.

TX FSM:
- T_IDLE: if TX not empty && !r_wait_i → load r_din_o from head, pop, go T_SEND.
- T_SEND: r_wr_o=1 for exactly this cycle → T_HOLD.
- T_HOLD: r_wr_o=0, guard cycle while router updates wait → T_IDLE.
- r_din_o holds its value outside T_SEND.
- Peak rate: 1 flit per 3 cycles. Latency from push into an empty FIFO to r_wr_o=1: 2 cycles.
- r_wait_i is sampled only in T_IDLE.

RX FSM:
- R_IDLE: if r_nd_i && RX not full → write r_dout_i into RX FIFO, go R_ACK.
- If RX is full, remain in R_IDLE; the router holds the flit.
- R_ACK: r_rd_o=1 for exactly this cycle → R_GAP.
- R_GAP: r_rd_o=0, guard cycle for r_nd_i to update → R_IDLE.

RX slave side:
- s_nd_o = !empty; s_dout_o = head when nonempty, else 0.
- s_rd_i pops when nonempty; s_rd_i while empty is ignored (no error).
- RX push and s_rd_i pop in the same cycle: level unchanged.
- A flit written in cycle N is visible on s_dout_o/s_nd_o in cycle N+1.

General:
- TX and RX paths are fully independent and may be active in the same cycle.

Test Plan:
- Reset, then single TX: push s_din_i=42'h0AB_CDEF_0123, r_wait_i=0 → r_wr_o high for one cycle 2 cycles later with r_din_o=42'h0AB_CDEF_0123; tx_level returns to 0.
- TX back-pressure and overflow: hold r_wait_i=1, push 5 flits 1..5 → s_wait_o=1 after 4th; 5th dropped; tx_ovf_o=1. Release wait → r_wr_o pulses 4 times, 3 cycles apart, data 1,2,3,4. ovf_clr_i → tx_ovf_o=0.
- RX path: r_nd_i=1, r_dout_i=42'h155 → one r_rd_o pulse; next cycle s_nd_o=1, s_dout_o=42'h155. s_rd_i → s_nd_o=0, s_dout_o=0.
- RX full: router offers 6 flits, s_rd_i=0 → exactly 4 r_rd_o pulses, rx_level=4, r_rd_o stays low. One s_rd_i pop → 5th flit accepted within 2 cycles.
- Simultaneous: push TX and pop RX every cycle while the router streams both directions → no loss, order preserved, levels never exceed depth.
- Reset mid-operation: assert rst_n_i during T_SEND/R_ACK → r_wr_o/r_rd_o drop immediately, levels=0; after release, no stale flit appears.
